cpu_debug_ctrl: RTL

- Run-control sequencer for the RV32 core. It owns the core's halt input and supports three modes: free-run, halt, and N-instruction single-step.
- It halts the core when the core reports a breakpoint (EBREAK reaching write-back), and it keeps retired-instruction and active-cycle counters.
- It sits between the debug harness command port and the core's halt, breakpoint_fired and instruction_retired pins.

---
 rtl/cpu_dbg_pkg.sv | 22 ++
 rtl/cpu_debug_ctrl_counter.sv | 38 +++
 rtl/cpu_debug_ctrl.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/cpu_dbg_pkg.sv
// cpu_dbg_pkg: shared encodings for the CPU run-control sequencer.
//   cmd_op_e    : debug harness command opcodes
//   dbg_state_e : run-control states, also driven out on state_o
package cpu_dbg_pkg;

    localparam int unsigned CMD_W   = 2;
    localparam int unsigned STATE_W = 2;

    typedef enum logic [CMD_W-1:0] {
        CMD_HALT = 2'b00,
        CMD_RUN  = 2'b01,
        CMD_STEP = 2'b10,
        CMD_CLR  = 2'b11
    } cmd_op_e;

    typedef enum logic [STATE_W-1:0] {
        ST_HALTED = 2'b00,
        ST_RUN    = 2'b01,
        ST_STEP   = 2'b10
    } dbg_state_e;

endpackage

// File: rtl/cpu_debug_ctrl_counter.sv
// dbg_counter: free-running event counter with enable, synchronous clear and wrap.
//   clk, rst_n : clock, async active-low reset
//   en         : count one event this cycle
//   clr        : zero the counter (wins over en)
//   cnt_o      : registered count, wraps modulo 2^CNT_W
module dbg_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/cpu_debug_ctrl.sv
// cpu_debug_ctrl: run-control sequencer for the RV32 core (free-run, halt,
// N-instruction single-step, breakpoint halt, retire/active-cycle counters).
//   cmd_valid/cmd_ready/cmd_op/cmd_arg : debug harness command port
//   dbg_abort                          : force HALTED, highest priority
//   bp_enable, breakpoint_fired        : breakpoint halt request from the core
//   instruction_retired                : retire strobe from the core
//   halt, state_o, bp_hit, step_done   : registered run-control status
//   steps_left, retire_cnt, active_cnt : registered counters
module cpu_debug_ctrl
    import cpu_dbg_pkg::*;
#(
    parameter int unsigned STEP_W       = 16,
    parameter int unsigned CNT_W        = 32,
    parameter bit          RESET_HALTED = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [CMD_W-1:0]  cmd_op,
    input  logic [STEP_W-1:0] cmd_arg,
    input  logic              dbg_abort,
    input  logic              bp_enable,
    input  logic              breakpoint_fired,
    input  logic              instruction_retired,
    output logic              halt,
    output logic [STATE_W-1:0] state_o,
    output logic              bp_hit,
    output logic              step_done,
    output logic [STEP_W-1:0] steps_left,
    output logic [CNT_W-1:0]  retire_cnt,
    output logic [CNT_W-1:0]  active_cnt
);

    localparam dbg_state_e RST_STATE = RESET_HALTED ? ST_HALTED : ST_RUN;

    dbg_state_e        state_q,      state_d;
    logic              halt_q;
    logic              bp_hit_q,     bp_hit_d;
    logic              step_done_q,  step_done_d;
    logic [STEP_W-1:0] steps_left_q, steps_left_d;

    logic retire_ok;
    logic bp_req;
    logic cmd_fire;
    logic step_last;
    logic cnt_clr;

    // A retire only counts while the core is actually running.
    assign retire_ok = instruction_retired && !halt_q;
    assign bp_req    = bp_enable && breakpoint_fired;
    assign cmd_ready = !dbg_abort && (state_q != ST_STEP);
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign step_last = retire_ok && (steps_left_q == STEP_W'(1));

    // Next-state, step bookkeeping and counter clear.
    always_comb begin
        state_d      = state_q;
        bp_hit_d     = bp_hit_q;
        step_done_d  = 1'b0;
        steps_left_d = steps_left_q;
        cnt_clr      = 1'b0;

        if (dbg_abort) begin
            state_d      = ST_HALTED;
            steps_left_d = '0;
        end else if (state_q == ST_STEP) begin
            if (step_last) begin
                steps_left_d = '0;
                step_done_d  = 1'b1;
                state_d      = ST_HALTED;
            end else if (retire_ok && !bp_req) begin
                steps_left_d = steps_left_q - STEP_W'(1);
            end
            if (bp_req) begin
                state_d  = ST_HALTED;
                bp_hit_d = 1'b1;
            end
        end else if ((state_q == ST_RUN) && bp_req) begin
            // Breakpoint beats, and drops, any command accepted this cycle.
            state_d  = ST_HALTED;
            bp_hit_d = 1'b1;
        end else if (cmd_fire) begin
            case (cmd_op_e'(cmd_op))
                CMD_HALT: state_d = ST_HALTED;
                CMD_RUN: begin
                    state_d  = ST_RUN;
                    bp_hit_d = 1'b0;
                end
                CMD_STEP: begin
                    if (cmd_arg == '0) begin
                        step_done_d = 1'b1;
                    end else begin
                        steps_left_d = cmd_arg;
                        state_d      = ST_STEP;
                        bp_hit_d     = 1'b0;
                    end
                end
                CMD_CLR:  cnt_clr = 1'b1;
                default:  state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RST_STATE;
            halt_q       <= RESET_HALTED;
            bp_hit_q     <= 1'b0;
            step_done_q  <= 1'b0;
            steps_left_q <= '0;
        end else begin
            state_q      <= state_d;
            halt_q       <= (state_d == ST_HALTED);
            bp_hit_q     <= bp_hit_d;
            step_done_q  <= step_done_d;
            steps_left_q <= steps_left_d;
        end
    end

    dbg_counter #(.CNT_W(CNT_W)) u_retire_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (retire_ok),
        .clr   (cnt_clr),
        .cnt_o (retire_cnt)
    );

    dbg_counter #(.CNT_W(CNT_W)) u_active_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (!halt_q),
        .clr   (cnt_clr),
        .cnt_o (active_cnt)
    );

    assign halt       = halt_q;
    assign state_o    = state_q;
    assign bp_hit     = bp_hit_q;
    assign step_done  = step_done_q;
    assign steps_left = steps_left_q;

endmodule
